dnn_result_argmax: RTL and testbench

Parametrised result stage behind the fixed-point inference engine. Captures the engine's per-class output vector when the engine signals completion, then scans it sequentially (one compare per cycle) to produce the predicted class index and its score. Provides registered indexed readout of any captured class score, with width and class count set by parameters.

---
 rtl/dnn_result_argmax.sv | 138 +++++++++++++
 tb/tb_dnn_result_argmax.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_result_argmax.sv
// rtl/dnn_result_argmax.sv - captures a class-score vector and finds its argmax with one compare per cycle
// Optional best-minus-second margin output is enabled with DNN_ARGMAX_MARGIN_EN.
module dnn_result_argmax #(
  parameter int DATA_WIDTH  = 14,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              scores_valid_i,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [IDX_WIDTH-1:0]              pred_idx_o,
  output logic signed [DATA_WIDTH-1:0]      pred_score_o,
  input  logic [IDX_WIDTH-1:0]              out_idx_i,
  output logic signed [DATA_WIDTH-1:0]      out_o
`ifdef DNN_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_WIDTH:0]               margin_o
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                       state_q;
  logic signed [DATA_WIDTH-1:0] bank_q [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]         cnt_q;
  logic [IDX_WIDTH-1:0]         cnt_d;
  logic [IDX_WIDTH-1:0]         best_idx_q;
  logic signed [DATA_WIDTH-1:0] best_q;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic                         busy_q;
  logic                         done_q;

  logic signed [DATA_WIDTH-1:0] cand;
  logic signed [DATA_WIDTH-1:0] rd_d;
  logic                         cand_gt_best;
  logic                         capture;

  // A new vector is only accepted outside SCAN so an in-flight scan is never disturbed.
  always_comb begin
    cand         = bank_q[cnt_q];
    cnt_d        = cnt_q + IDX_WIDTH'(1);
    cand_gt_best = cand > best_q;
    capture      = scores_valid_i && (state_q != SCAN);
    rd_d         = (int'(out_idx_i) < NUM_CLASSES) ? bank_q[out_idx_i] : bank_q[0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) bank_q[i] <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) bank_q[i] <= '0;
    end else begin
      out_q <= rd_d;
      if (capture) begin
        for (int i = 0; i < NUM_CLASSES; i++) bank_q[i] <= scores_in_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      case (state_q)
        IDLE, DONE: begin
          if (capture) begin
            state_q    <= SCAN;
            best_q     <= scores_in_i[DATA_WIDTH-1:0];
            best_idx_q <= '0;
            cnt_q      <= IDX_WIDTH'(1);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        SCAN: begin
          // Strictly-greater replacement keeps the lowest index on ties.
          if (cand_gt_best) begin
            best_q     <= cand;
            best_idx_q <= cnt_q;
          end
          cnt_q <= cnt_d;
          if (cnt_q == LAST_IDX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DNN_ARGMAX_MARGIN_EN
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] second_q;
  logic                         cand_gt_second;

  always_comb cand_gt_second = cand > second_q;

  // Seeding with the most negative value lets any real score take the second slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      second_q <= '0;
    end else if (clear_i) begin
      second_q <= '0;
    end else if (state_q != SCAN) begin
      if (capture) second_q <= MIN_SCORE;
    end else if (cand_gt_best) begin
      second_q <= best_q;
    end else if (cand_gt_second) begin
      second_q <= cand;
    end
  end

  assign margin_o = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};
`endif

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pred_idx_o   = best_idx_q;
  assign pred_score_o = best_q;
  assign out_o        = out_q;

endmodule

// File: tb/tb_dnn_result_argmax.sv
// tb/tb_dnn_result_argmax.sv - directed scoreboard bench for dnn_result_argmax
// Margin checks are compiled in when DNN_ARGMAX_MARGIN_EN is defined.
module tb_dnn_result_argmax;

  typedef struct {
    int idx;
    int score;
    int lat;
    int margin;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         scores_valid;
  logic [139:0] scores_in;
  logic         busy;
  logic         done;
  logic [3:0]   pred_idx;
  logic signed [13:0] pred_score;
  logic [3:0]   out_idx;
  logic signed [13:0] out;

  logic         sv2;
  logic [15:0]  scores2;
  logic         busy2;
  logic         done2;
  logic [0:0]   pidx2;
  logic signed [7:0] pscore2;
  logic [0:0]   oidx2;
  logic signed [7:0] out2;
`ifdef DNN_ARGMAX_MARGIN_EN
  logic [14:0]  margin;
  logic [8:0]   margin2;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   rd_q[$];
  int   bank_m[10];

  dnn_result_argmax u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .scores_valid_i(scores_valid), .scores_in_i(scores_in),
    .busy_o(busy), .done_o(done), .pred_idx_o(pred_idx), .pred_score_o(pred_score),
    .out_idx_i(out_idx), .out_o(out)
`ifdef DNN_ARGMAX_MARGIN_EN
    , .margin_o(margin)
`endif
  );

  dnn_result_argmax #(.DATA_WIDTH(8), .NUM_CLASSES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .scores_valid_i(sv2), .scores_in_i(scores2),
    .busy_o(busy2), .done_o(done2), .pred_idx_o(pidx2), .pred_score_o(pscore2),
    .out_idx_i(oidx2), .out_o(out2)
`ifdef DNN_ARGMAX_MARGIN_EN
    , .margin_o(margin2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int s[10]);
    exp_t e;
    int   best;
    int   second;
    best   = 0;
    second = -2147483647;
    for (int i = 1; i < 10; i++) if (s[i] > s[best]) best = i;
    for (int i = 0; i < 10; i++) if (i != best && s[i] > second) second = s[i];
    e.idx    = best;
    e.score  = s[best];
    e.lat    = 9;
    e.margin = s[best] - second;
    return e;
  endfunction

  task automatic capture(input int s[10]);
    for (int i = 0; i < 10; i++) begin
      scores_in[i*14 +: 14] = s[i][13:0];
      bank_m[i] = s[i];
    end
    exp_q.push_back(model(s));
    scores_valid = 1'b1;
    tick();
    scores_valid = 1'b0;
  endtask

  // Runs until done, optionally firing a junk vector mid-scan, then pops and checks the scoreboard.
  task automatic wait_done(input int inject_at);
    int   cyc;
    int   busy_n;
    exp_t e;
    cyc    = 0;
    busy_n = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      if (cyc == inject_at) begin
        scores_valid = 1'b1;
        scores_in    = {10{14'h1fff}};
      end
      tick();
      scores_valid = 1'b0;
      cyc++;
      if (!done && busy) busy_n++;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("done_latency", cyc, e.lat);
      check("busy_cycles", busy_n, e.lat);
      check("busy_in_done", busy, 0);
      check("pred_idx", pred_idx, e.idx);
      check("pred_score", pred_score, e.score);
`ifdef DNN_ARGMAX_MARGIN_EN
      check("margin", margin, e.margin);
`endif
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pred_idx"}, pred_idx, 0);
    check({tag, "_pred_score"}, pred_score, 0);
    check({tag, "_out"}, out, 0);
`ifdef DNN_ARGMAX_MARGIN_EN
    check({tag, "_margin"}, margin, 0);
`endif
  endtask

  initial begin
    int sa[10];
    int prev;
    int cyc;
    int e;
    rst          = 1'b1;
    clear        = 1'b0;
    scores_valid = 1'b0;
    scores_in    = '0;
    out_idx      = '0;
    sv2          = 1'b0;
    scores2      = '0;
    oidx2        = '0;
    tick();
    tick();
    check_zero("reset");
    check("reset_n2_done", done2, 0);
    check("reset_n2_out", out2, 0);
    rst = 1'b0;
    tick();
    check_zero("post_reset");

    // Ties resolve to the lower index; a vector offered mid-scan is dropped.
    sa = '{0, 5, -3, 7, 2, 7, 1, 0, -8, 6};
    capture(sa);
    check("capture_busy", busy, 1);
    wait_done(3);
    out_idx = 4'd3;
    tick();
    tick();
    check("bank_kept_3", out, 7);
    out_idx = 4'd9;
    tick();
    tick();
    check("bank_kept_9", out, 6);
    tick();
    check("pred_hold_idx", pred_idx, 3);
    check("pred_hold_done", done, 1);
    out_idx = 4'd0;

    sa = '{-100, -5, -8192, -300, -7, -8000, -50, -9, -20, -6};
    capture(sa);
    wait_done(-1);
    tick();
    prev = bank_m[0];
    for (int k = 0; k < 16; k++) begin
      out_idx = k[3:0];
      rd_q.push_back(bank_m[(k < 10) ? k : 0]);
      #1;
      check("out_hold", out, prev);
      tick();
      e = rd_q.pop_front();
      check("out_sweep", out, e);
      prev = e;
    end
    out_idx = 4'd2;

    // Asynchronous reset in the middle of a scan.
    sa = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    capture(sa);
    tick();
    tick();
    tick();
    check("pre_abort_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    check_zero("async_rst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    sa = '{10, -20, 30, -40, 50, -60, 70, -80, 90, -100};
    capture(sa);
    wait_done(-1);
    tick();
    check("out_after_rescan", out, 30);

    // Recapture from DONE with the maximum at the last class.
    check("done_before_recap", done, 1);
    sa = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
    capture(sa);
    check("recap_done_drop", done, 0);
    check("recap_busy", busy, 1);
    wait_done(-1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_zero("clear");

    // Two classes at 8 bits: extreme values.
    scores2 = 16'h807f;
    sv2 = 1'b1;
    tick();
    sv2 = 1'b0;
    check("n2_busy", busy2, 1);
    cyc = 0;
    while (!done2 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("n2_latency", cyc, 1);
    check("n2_busy_done", busy2, 0);
    check("n2_pred_idx", pidx2, 0);
    check("n2_pred_score", pscore2, 127);
`ifdef DNN_ARGMAX_MARGIN_EN
    check("n2_margin", margin2, 255);
`endif
    oidx2 = 1'b1;
    tick();
    check("n2_out1", out2, -128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
